// File: rtl/sc_mul_acc.sv
// Unsigned accumulator behind the SC multiplier; folds cfg_len products into one result.
// Define SC_MUL_ACC_SAT_EN to clamp at all-ones on overflow; otherwise the sum wraps.
module sc_mul_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = DATA_WIDTH << 1,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OUT_WIDTH-1:0] in_data,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;

    logic                 beat;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_add;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] eff_len;

    assign in_ready = (state_q != DONE);
    assign beat     = in_valid && in_ready;
    assign in_ext   = ACC_WIDTH'(in_data);
    assign cnt_inc  = cnt_q + 1'b1;
    // A zero length would never terminate, so it runs as a single beat.
    assign eff_len  = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;

`ifdef SC_MUL_ACC_SAT_EN
    logic [ACC_WIDTH:0] sum_full;
    logic               sat_q, sat_d;

    assign sum_full = {1'b0, acc_q} + {1'b0, in_ext};
    assign acc_add  = sum_full[ACC_WIDTH] ? '1 : sum_full[ACC_WIDTH-1:0];

    always_comb begin
        sat_d = sat_q;
        if (clear) begin
            sat_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (beat) sat_d = 1'b0;
                ACC:  if (beat) sat_d = sat_q | sum_full[ACC_WIDTH];
                DONE: if (out_ready) sat_d = 1'b0;
                default: sat_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign out_sat = sat_q;
`else
    assign acc_add = acc_q + in_ext;
    assign out_sat = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d   = in_ext;
                        cnt_d   = CNT_WIDTH'(1);
                        len_d   = eff_len;
                        state_d = (eff_len == CNT_WIDTH'(1)) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = acc_add;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= CNT_WIDTH'(1);
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sc_mul_acc.sv
// Directed bench for sc_mul_acc: vector table plus backpressure, clear,
// async reset and 32-bit overflow sequences.
module tb_sc_mul_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, clear, out_valid, out_ready, out_sat, busy;
    logic [31:0] in_data;
    logic [7:0]  cfg_len;
    logic [39:0] out_data;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sat_b, busy_b;
    logic [31:0] in_data_b, out_data_b;
    logic [7:0]  cfg_len_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sc_mul_acc u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_len(cfg_len), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    sc_mul_acc #(.ACC_WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .cfg_len(cfg_len_b), .clear(1'b0),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_sat(out_sat_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0]  len;
        int          n;
        logic [31:0] d [4];
        int          gap;
        logic [39:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Beats are driven at negedge; cfg_len is scrambled after the first beat.
    task automatic run_vec(input vec_t v, input string tag);
        for (int i = 0; i < v.n; i++) begin
            chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = v.d[i];
            cfg_len  = (i == 0) ? v.len : 8'hAA;
            @(negedge clk);
            in_valid = 1'b0;
            if (i == 0) repeat (v.gap) @(negedge clk);
        end
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"}, 64'(out_data), 64'(v.exp));
        chk({tag, ".sat"}, 64'(out_sat), 64'd0);
        chk({tag, ".bubble"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        chk({tag, ".drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{len: 8'd4, n: 4, d: '{100, 200, 300, 400}, gap: 0, exp: 40'd1000};
        vecs[1] = '{len: 8'd0, n: 1, d: '{42, 0, 0, 0}, gap: 0, exp: 40'd42};
        vecs[2] = '{len: 8'd3, n: 3, d: '{5, 6, 7, 0}, gap: 2, exp: 40'd18};
        vecs[3] = '{len: 8'd1, n: 1, d: '{7, 0, 0, 0}, gap: 0, exp: 40'd7};
        vecs[4] = '{len: 8'd2, n: 2, d: '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0},
                    gap: 0, exp: 40'h1FFFFFFFE};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_len = '0;
        clear = 1'b0; out_ready = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; cfg_len_b = '0; out_ready_b = 1'b1;
        #12;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.ready", 64'(in_ready), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.data", 64'(out_data), 64'd0);
        chk("rst.sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Backpressure with cfg_len changed after first beat
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFFFFFF; cfg_len = 8'd2;
        @(negedge clk);
        in_data = 32'd1; cfg_len = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp.valid", 64'(out_valid), 64'd1);
            chk("bp.data", 64'(out_data), 64'h100000000);
            chk("bp.ready", 64'(in_ready), 64'd0);
            if (k == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp.release", 64'(out_valid), 64'd0);
        chk("bp.idle", 64'(busy), 64'd0);
        chk("bp.rdy", 64'(in_ready), 64'd1);

        // Clear together with the 3rd beat
        cfg_len = 8'd4; in_data = 32'd9; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clr.busy", 64'(busy), 64'd0);
        chk("clr.data", 64'(out_data), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("clr.novalid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        run_vec('{len: 8'd4, n: 4, d: '{1, 1, 1, 1}, gap: 0, exp: 40'd4}, "clr.next");

        // Async reset after 2 of 4 beats, checked between clock edges
        cfg_len = 8'd4; in_data = 32'd10; in_valid = 1'b1;
        @(negedge clk);
        in_data = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar.pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.busy", 64'(busy), 64'd0);
        chk("ar.ready", 64'(in_ready), 64'd1);
        chk("ar.data", 64'(out_data), 64'd0);
        chk("ar.valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec('{len: 8'd4, n: 4, d: '{1, 2, 3, 4}, gap: 0, exp: 40'd10}, "ar.fresh");

        // 32-bit accumulator overflow
        in_valid_b = 1'b1; in_data_b = 32'hFFFFFFFF; cfg_len_b = 8'd2;
        @(negedge clk);
        in_data_b = 32'd2;
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("ovf.valid", 64'(out_valid_b), 64'd1);
`ifdef SC_MUL_ACC_SAT_EN
        chk("ovf.data", 64'(out_data_b), 64'hFFFFFFFF);
        chk("ovf.sat", 64'(out_sat_b), 64'd1);
`else
        chk("ovf.data", 64'(out_data_b), 64'd1);
        chk("ovf.sat", 64'(out_sat_b), 64'd0);
`endif
        @(negedge clk);
        chk("ovf.idle", 64'(busy_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_mul_acc.md
SC_MUL_ACC -- requirements
Module: sc_mul_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand width of the upstream SC multiplier.
REQ-002 Parameter OUT_WIDTH, default DATA_WIDTH<<1: width of each incoming product.
REQ-003 Parameter ACC_WIDTH, default 40: accumulator and result width; SHALL be >= OUT_WIDTH.
REQ-004 Parameter CNT_WIDTH, default 8: width of the beat counter and the length field.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning), clock and reset first:
- clk, input, 1: single clock; all state on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: a product is presented.
- in_ready, output, 1: the block can accept a product.
- in_data, input, OUT_WIDTH: unsigned product from the SC multiplier top.
- cfg_len, input, CNT_WIDTH: number of products per result, sampled on the first beat only.
- clear, input, 1: synchronous abort of the current accumulation.
- out_valid, output, 1: the result is available.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, ACC_WIDTH: accumulated sum.
- out_sat, output, 1: the sum saturated during this accumulation.
- busy, output, 1: the block is in ACC or DONE.

Function
REQ-006 States: IDLE, ACC, DONE. The state register SHALL be encoded in 2 bits.
REQ-007 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE. A beat is accepted when in_valid and in_ready are both 1.
REQ-008 Accepted beat in IDLE:
- acc <= zero-extended in_data; cnt <= 1.
- len <= cfg_len, with a cfg_len of 0 treated as 1.
- Next state is DONE if the effective length is 1, otherwise ACC.
REQ-009 Accepted beat in ACC:
- acc <= acc + in_data; cnt <= cnt + 1.
- When cnt+1 == len, next state is DONE; otherwise the state stays ACC.
- No beat in a cycle means all state holds.
REQ-010 Changes to cfg_len after the first beat SHALL NOT affect the current accumulation.
REQ-011 out_valid SHALL be registered and equal 1 exactly while in DONE. out_valid rises in the cycle after the last beat is accepted (latency 1).
REQ-012 out_data SHALL equal acc and stay stable while out_valid=1. out_sat SHALL be stable while out_valid=1.
REQ-013 In DONE, out_ready=1 returns the block to IDLE next cycle. out_valid=0 while out_ready=0 SHALL NOT happen; out_valid holds until out_ready=1.
REQ-014 Throughput: at most one result per len+1 cycles. The in_ready bubble in DONE is mandatory.
REQ-015 clear=1 in any state SHALL, next cycle, give: state IDLE, acc=0, cnt=0, out_valid=0, out_sat=0.
REQ-016 clear SHALL take priority over a simultaneous input beat or output handshake. A beat presented with clear SHALL be dropped.
REQ-017 Arithmetic is unsigned only. The full sum is computed in ACC_WIDTH+1 bits before the overflow rule of REQ-020/021 is applied.
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 While rst_n=0, independent of clk, the block SHALL be held with:
- state=IDLE, acc=0, cnt=0, len=1.
- out_valid=0, out_sat=0, out_data=0.
- in_ready=1, busy=0.
Reset asserted mid-accumulation SHALL discard the partial sum with no result emitted.

Configuration
REQ-020 With macro SC_MUL_ACC_SAT_EN defined:
- A sum whose carry-out bit is set SHALL clamp acc to all-ones (2^ACC_WIDTH-1).
- out_sat SHALL be set to 1 for the rest of the accumulation.
- Further adds keep acc at all-ones.
REQ-021 With SC_MUL_ACC_SAT_EN undefined:
- acc SHALL wrap modulo 2^ACC_WIDTH.
- out_sat SHALL be tied to 0.
- No saturation logic is instantiated.

Verification
REQ-022 Basic: cfg_len=4, products 100, 200, 300, 400 on back-to-back cycles, out_ready=1 -> out_valid for 1 cycle, one cycle after the 4th beat; out_data=1000; out_sat=0; in_ready=0 in that cycle.
REQ-023 Backpressure and length change: cfg_len=2, beats 0xFFFFFFFF, 1, out_ready=0 for 5 cycles; cfg_len changed to 7 after the first beat -> out_data=0x100000000 held stable for 5 cycles with in_ready=0; returns to IDLE the cycle after out_ready=1.
REQ-024 Zero length and gaps: cfg_len=0, one beat of 42 -> out_data=42 after 1 cycle. Then cfg_len=3 with in_valid gaps (beat, 2 idle cycles, beat, beat) of 5, 6, 7 -> out_data=18.
REQ-025 Clear: cfg_len=4; clear asserted together with the 3rd beat -> no out_valid; next run of beats 1, 1, 1, 1 gives out_data=4.
REQ-026 Overflow with ACC_WIDTH=32, cfg_len=2, beats 0xFFFFFFFF and 2:
- SC_MUL_ACC_SAT_EN defined -> out_data=0xFFFFFFFF, out_sat=1.
- SC_MUL_ACC_SAT_EN undefined -> out_data=1, out_sat=0.
REQ-027 Async reset: rst_n pulled low mid-cycle during ACC after 2 of 4 beats -> outputs take reset values immediately, without waiting for a clock edge; the first run after release produces a correct fresh sum.
